// File: rtl/riscv_soft_dmem_pkg.sv
`default_nettype none
//==============================================================================
// Module   : riscv_soft_dmem_pkg
// Brief    : Memory-op and funct3 encodings shared with the riscv_soft core,
//            plus the IDLE/BUSY state type and lane helper functions.
// Revision : 1.0 - initial release
//==============================================================================
package riscv_soft_dmem_pkg;

   localparam logic [1:0] MEM_LOAD  = 2'd0;
   localparam logic [1:0] MEM_STORE = 2'd1;
   localparam logic [1:0] MEM_FENCE = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } dmem_state_t;

   function automatic logic f3_is_load(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   function automatic logic f3_is_store(input logic [2:0] f3);
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
   endfunction

   function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] addr);
      return ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr != 2'b00));
   endfunction

   function automatic logic [1:0] addr_align(input logic [1:0] size, input logic [1:0] addr);
      logic [1:0] a;
      a = addr;
      if (size == SZ_HALF) a[0] = 1'b0;
      else if (size == SZ_WORD) a = 2'b00;
      return a;
   endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_soft_dmem_if.sv
`default_nettype none
//==============================================================================
// Module   : riscv_soft_dmem_if
// Brief    : d_cache request/response bundle between core and data memory.
// Revision : 1.0 - initial release
//==============================================================================
interface riscv_soft_dmem_if #(
   parameter int XPR_LEN = 32
);
   logic               req_valid;
   logic               req_ready;
   logic [1:0]         req_op;
   logic [2:0]         req_op_type;
   logic [XPR_LEN-1:0] req_addr;
   logic [XPR_LEN-1:0] req_data;
   logic               resp_valid;
   logic [XPR_LEN-1:0] resp_data;
   logic               resp_misaligned;

   modport master (
      output req_valid, req_op, req_op_type, req_addr, req_data,
      input  req_ready, resp_valid, resp_data, resp_misaligned
   );

   modport slave (
      input  req_valid, req_op, req_op_type, req_addr, req_data,
      output req_ready, resp_valid, resp_data, resp_misaligned
   );
endinterface
`default_nettype wire

// File: rtl/riscv_soft_dmem_lane.sv
`default_nettype none
//==============================================================================
// Module   : riscv_soft_dmem_lane
// Brief    : Combinational store merge, load extract/extend and misalign
//            detect. Option macro: RISCV_SOFT_DMEM_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
//==============================================================================
module riscv_soft_dmem_lane
   import riscv_soft_dmem_pkg::*;
#(
   parameter int XPR_LEN = 32
) (
   input  logic [1:0]         i_op,
   input  logic [2:0]         i_op_type,
   input  logic [1:0]         i_addr_lo,
   input  logic [31:0]        i_wdata,
   input  logic [31:0]        i_rword,
   output logic [3:0]         o_be,
   output logic [31:0]        o_wword,
   output logic [XPR_LEN-1:0] o_rdata,
   output logic               o_misaligned
);

   logic       w_load_ok;
   logic       w_store_ok;
   logic       w_mis;
   logic [1:0] w_size;
   logic [1:0] w_addr;
   logic [7:0] w_byte;
   logic [15:0] w_half;

   assign w_size = i_op_type[1:0];

   always_comb begin
      w_load_ok  = (i_op == MEM_LOAD)  && f3_is_load(i_op_type);
      w_store_ok = (i_op == MEM_STORE) && f3_is_store(i_op_type);
`ifdef RISCV_SOFT_DMEM_MISALIGN_TRAP_EN
      w_addr = i_addr_lo;
      w_mis  = (w_load_ok || w_store_ok) && addr_misaligned(w_size, i_addr_lo);
`else
      // Misaligned accesses silently fold onto the naturally aligned location.
      w_addr = addr_align(w_size, i_addr_lo);
      w_mis  = 1'b0;
`endif
   end

   always_comb begin
      o_be    = 4'b0000;
      o_wword = i_wdata;
      case (w_size)
         SZ_BYTE: begin
            o_be    = 4'b0001 << w_addr;
            o_wword = {4{i_wdata[7:0]}};
         end
         SZ_HALF: begin
            o_be    = w_addr[1] ? 4'b1100 : 4'b0011;
            o_wword = {2{i_wdata[15:0]}};
         end
         default: o_be = 4'b1111;
      endcase
      if (!w_store_ok || w_mis) o_be = 4'b0000;
   end

   assign w_byte = i_rword[{w_addr, 3'b000} +: 8];
   assign w_half = w_addr[1] ? i_rword[31:16] : i_rword[15:0];

   always_comb begin
      o_rdata = '0;
      case (w_size)
         SZ_BYTE: o_rdata = i_op_type[2] ? XPR_LEN'(w_byte) : XPR_LEN'($signed(w_byte));
         SZ_HALF: o_rdata = i_op_type[2] ? XPR_LEN'(w_half) : XPR_LEN'($signed(w_half));
         default: o_rdata = XPR_LEN'($signed(i_rword));
      endcase
      if (!w_load_ok || w_mis) o_rdata = '0;
   end

   assign o_misaligned = w_mis;

endmodule
`default_nettype wire

// File: rtl/riscv_soft_dmem.sv
`default_nettype none
//==============================================================================
// Module   : riscv_soft_dmem
// Brief    : Data-memory responder with programmable wait states for the
//            riscv_soft core. Option macro: RISCV_SOFT_DMEM_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
//==============================================================================
module riscv_soft_dmem
   import riscv_soft_dmem_pkg::*;
#(
   parameter int XPR_LEN     = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   riscv_soft_dmem_if.slave bus
);

   localparam int c_IDX_W = $clog2(DEPTH_WORDS);

   dmem_state_t        r_state;
   dmem_state_t        w_state_nxt;
   logic [3:0]         r_cnt;
   logic [3:0]         w_cnt_nxt;
   logic               w_req_ready;
   logic               w_resp_valid;
   logic               w_accept;
   logic [c_IDX_W-1:0] w_idx;
   logic [31:0]        r_mem [DEPTH_WORDS];
   logic [31:0]        w_rword;
   logic [31:0]        w_wword;
   logic [3:0]         w_be;
   logic [XPR_LEN-1:0] w_rdata;
   logic [XPR_LEN-1:0] r_resp_data;
   logic               w_mis;
   logic               r_resp_mis;
   logic               w_unused_addr;

   // Upper address bits are deliberately ignored: the array aliases.
   assign w_idx         = bus.req_addr[c_IDX_W+1:2];
   assign w_unused_addr = ^bus.req_addr[XPR_LEN-1:c_IDX_W+2];
   assign w_accept      = bus.req_valid && w_req_ready;
   assign w_rword       = r_mem[w_idx];

   riscv_soft_dmem_lane #(
      .XPR_LEN (XPR_LEN)
   ) u_lane (
      .i_op         (bus.req_op),
      .i_op_type    (bus.req_op_type),
      .i_addr_lo    (bus.req_addr[1:0]),
      .i_wdata      (bus.req_data[31:0]),
      .i_rword      (w_rword),
      .o_be         (w_be),
      .o_wword      (w_wword),
      .o_rdata      (w_rdata),
      .o_misaligned (w_mis)
   );

   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_req_ready  = 1'b0;
      w_resp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req_ready  = 1'b1;
            w_resp_valid = 1'b1;
            if (bus.req_valid && (WAIT_CYCLES != 0)) begin
               w_state_nxt = ST_BUSY;
               w_cnt_nxt   = 4'(WAIT_CYCLES);
            end
         end
         ST_BUSY: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_resp_data <= '0;
         r_resp_mis  <= 1'b0;
      end else if (w_accept) begin
         r_resp_data <= w_rdata;
         r_resp_mis  <= w_mis;
      end
   end

   assign bus.req_ready       = w_req_ready;
   assign bus.resp_valid      = w_resp_valid;
   assign bus.resp_data       = r_resp_data;
   assign bus.resp_misaligned = r_resp_mis;

endmodule
`default_nettype wire
